// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Machine-level external interrupt controller. It collects NUM_SRC
// level-sensitive device interrupt lines through per-source gateways and
// arbitrates the pending, enabled sources by programmable priority against a
// threshold. The result drives meip for the CSR unit. A claim/complete
// register window is exposed to the load/store path over a simple
// request/response bus that never stalls.
//
// Source IDs run from 1 to NUM_SRC. ID 0 means "no interrupt".
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   irq_src    level interrupt lines, bit i-1 = source ID i
//   req_valid  bus request strobe (accepted every cycle)
//   req_write  1 = write, 0 = read
//   req_addr   byte address in the controller window, bits [1:0] ignored
//   req_wdata  write data
//   rsp_valid  one-cycle response pulse, one cycle after req_valid
//   rsp_rdata  registered read data (0 for writes)
//   meip       machine external interrupt pending, registered
//
// Register map (word addresses):
//   0x00+4*i  priority[i], i = 1..NUM_SRC (0x00 reads 0)
//   0x40      pending (RO), bit i = source i
//   0x44      enable, bit i = source i
//   0x48      threshold
//   0x4C      read = claim, write = complete
//
// Optional feature (compile-time macro IRQ_CTRL_SYNC_EN):
//   defined   -> each irq_src line goes through a 2-flop synchronizer
//                before its gateway (irq_src to meip latency 4 cycles)
//   undefined -> irq_src feeds the gateways directly (latency 2 cycles)
// ---------------------------------------------------------------------------
module irq_controller #(
   parameter int NUM_SRC   = 8,
   parameter int PRIO_BITS = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               req_valid,
   input  logic               req_write,
   input  logic [7:0]         req_addr,
   input  logic [31:0]        req_wdata,
   output logic               rsp_valid,
   output logic [31:0]        rsp_rdata,
   output logic               meip
);

   localparam int ID_W = 4;

   localparam logic [5:0] WORD_PENDING   = 6'h10;
   localparam logic [5:0] WORD_ENABLE    = 6'h11;
   localparam logic [5:0] WORD_THRESHOLD = 6'h12;
   localparam logic [5:0] WORD_CLAIM     = 6'h13;

   logic [PRIO_BITS-1:0] prio [1:NUM_SRC];
   logic [NUM_SRC:1]     enable;
   logic [NUM_SRC:1]     pending;
   logic [NUM_SRC:1]     in_flight;
   logic [PRIO_BITS-1:0] threshold;

   logic [NUM_SRC:1]     pending_nxt;
   logic [NUM_SRC:1]     in_flight_nxt;
   logic [NUM_SRC-1:0]   src_lvl;
   logic [ID_W-1:0]      best_id;
   logic [PRIO_BITS-1:0] best_prio;
   logic [31:0]          rd_data;
   logic [5:0]           word;
   logic                 claim;
   logic                 complete;
   logic [ID_W-1:0]      complete_id;

   // Address bits [1:0] and the upper write-data bits are don't-care.
   logic unused_bits;
   assign unused_bits = ^{req_addr[1:0], req_wdata};

   assign word        = req_addr[7:2];
   assign claim       = req_valid && !req_write && (word == WORD_CLAIM);
   assign complete    = req_valid &&  req_write && (word == WORD_CLAIM);
   assign complete_id = req_wdata[ID_W-1:0];

   // ------------------------------------------------------------------
   // Optional input synchronizer
   // ------------------------------------------------------------------
`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] sync_q1;
   logic [NUM_SRC-1:0] sync_q2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_src;
         sync_q2 <= sync_q1;
      end
   end

   assign src_lvl = sync_q2;
`else
   assign src_lvl = irq_src;
`endif

   // ------------------------------------------------------------------
   // Arbitration over registered state. Starting the running maximum at
   // the threshold folds "priority > threshold" into the compare. The
   // strict '>' in ascending ID order lets the lowest ID win ties, and it
   // keeps a priority-0 source from ever winning.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      best_id   = '0;
      best_prio = threshold;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
            best_prio = prio[i];
            best_id   = ID_W'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // Gateway, claim and complete next-state. A claimed source has
   // pending=1, so the gateway cannot set it in the same cycle. A completed
   // source still has in_flight=1 this cycle, so a held line re-pends on
   // the following edge.
   // ------------------------------------------------------------------
   always_comb begin
      pending_nxt   = pending;
      in_flight_nxt = in_flight;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (src_lvl[i-1] && !in_flight[i] && !pending[i])
            pending_nxt[i] = 1'b1;
         if (claim && (best_id == ID_W'(i))) begin
            pending_nxt[i]   = 1'b0;
            in_flight_nxt[i] = 1'b1;
         end
         if (complete && (complete_id == ID_W'(i)) && in_flight[i])
            in_flight_nxt[i] = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Read mux. Unmapped addresses read 0.
   // ------------------------------------------------------------------
   always_comb begin
      rd_data = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (word == 6'(i))
            rd_data = 32'(prio[i]);
      end
      case (word)
         WORD_PENDING:   rd_data = 32'({pending, 1'b0});
         WORD_ENABLE:    rd_data = 32'({enable, 1'b0});
         WORD_THRESHOLD: rd_data = 32'(threshold);
         WORD_CLAIM:     rd_data = 32'(best_id);
         default:        ;
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the priority array is a handful of flops, not a RAM, so it
         // is cleared by reset like the rest of the state.
         for (int i = 1; i <= NUM_SRC; i++)
            prio[i] <= '0;
         enable    <= '0;
         threshold <= '0;
         pending   <= '0;
         in_flight <= '0;
         meip      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register here samples
         // the pre-edge values of the others.
         pending   <= pending_nxt;
         in_flight <= in_flight_nxt;
         meip      <= (best_id != '0);
         rsp_valid <= req_valid;
         rsp_rdata <= (req_valid && !req_write) ? rd_data : '0;

         if (req_valid && req_write) begin
            for (int i = 1; i <= NUM_SRC; i++) begin
               if (word == 6'(i))
                  prio[i] <= req_wdata[PRIO_BITS-1:0];
            end
            if (word == WORD_ENABLE)
               enable <= req_wdata[NUM_SRC:1];
            if (word == WORD_THRESHOLD)
               threshold <= req_wdata[PRIO_BITS-1:0];
         end
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
//
// Directed bench for irq_controller in its default build (no input
// synchronizer, irq_src to meip latency of 2 cycles). Inputs change on the
// falling edge of clk, and outputs are sampled on the falling edge, away
// from the active rising edge.
// ---------------------------------------------------------------------------
module tb_irq_controller;

   logic        clk;
   logic        reset;
   logic [7:0]  irq_src;
   logic        req_valid;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        meip;

   int checks;
   int failures;

   irq_controller #(.NUM_SRC(8), .PRIO_BITS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_src   (irq_src),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .meip      (meip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One bus transaction. The request is held for one cycle. The response
   // is sampled on the next falling edge, one cycle after the request.
   task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] r);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      r = rsp_rdata;
      if (w) check("wr_rdata", r, 32'd0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus(1'b1, a, d, r);
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, a, 32'd0, r);
      check(tag, r, exp);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      irq_src   = '0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // ---- 1. reset, idle reads, back-to-back responses ----
      #12;
      check("reset_meip", {31'd0, meip}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("idle_meip", {31'd0, meip}, 32'd0);
      check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      rd("rd_pending0", 8'h40, 32'd0);
      rd("rd_enable0", 8'h44, 32'd0);
      rd("rd_thresh0", 8'h48, 32'd0);
      rd("rd_claim0", 8'h4C, 32'd0);
      tick();
      check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      // Two requests in consecutive cycles.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h44;
      tick();
      check("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
      req_addr = 8'h48;
      tick();
      req_valid = 1'b0; req_addr = '0;
      check("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);
      tick();
      check("b2b_drop", {31'd0, rsp_valid}, 32'd0);

      // ---- 2. basic flow ----
      wr(8'h0C, 32'd2);
      wr(8'h44, 32'h08);
      rd("rd_prio3", 8'h0C, 32'd2);
      rd("rd_enable08", 8'h44, 32'h08);
      irq_src = 8'h04;
      tick();
      check("lat_t1_meip", {31'd0, meip}, 32'd0);
      tick();
      check("lat_t2_meip", {31'd0, meip}, 32'd1);
      rd("claim_3", 8'h4C, 32'd3);
      tick();
      check("post_claim_meip", {31'd0, meip}, 32'd0);
      rd("claim_inflight", 8'h4C, 32'd0);
      rd("pending_inflight", 8'h40, 32'd0);
      wr(8'h4C, 32'd3);
      check("cmpl_meip0", {31'd0, meip}, 32'd0);
      tick();
      check("cmpl_meip1", {31'd0, meip}, 32'd0);
      tick();
      check("cmpl_meip2", {31'd0, meip}, 32'd1);
      rd("repend_pending", 8'h40, 32'h08);
      rd("claim_3b", 8'h4C, 32'd3);
      irq_src = '0;
      wr(8'h4C, 32'd3);
      tick();
      rd("clean_pending2", 8'h40, 32'd0);

      // ---- 3. arbitration ----
      wr(8'h08, 32'd5);
      wr(8'h14, 32'd5);
      wr(8'h1C, 32'd6);
      wr(8'h44, 32'hA4);
      irq_src = 8'h52;
      tick();
      tick();
      check("arb_meip", {31'd0, meip}, 32'd1);
      rd("arb_pending", 8'h40, 32'hA4);
      rd("arb_claim7", 8'h4C, 32'd7);
      rd("arb_claim2", 8'h4C, 32'd2);
      rd("arb_claim5", 8'h4C, 32'd5);
      rd("arb_claim0", 8'h4C, 32'd0);
      irq_src = '0;
      wr(8'h4C, 32'd7);
      wr(8'h4C, 32'd2);
      wr(8'h4C, 32'd5);
      tick();
      rd("arb_clean_pending", 8'h40, 32'd0);

      // ---- 4. threshold and priority gating ----
      wr(8'h04, 32'd3);
      wr(8'h48, 32'd3);
      wr(8'h44, 32'h02);
      irq_src = 8'h01;
      tick();
      tick();
      tick();
      check("thr_meip_gated", {31'd0, meip}, 32'd0);
      rd("thr_pending", 8'h40, 32'h02);
      wr(8'h48, 32'd2);
      check("thr_meip_t1", {31'd0, meip}, 32'd0);
      tick();
      check("thr_meip_t2", {31'd0, meip}, 32'd1);
      rd("thr_claim1", 8'h4C, 32'd1);
      irq_src = '0;
      wr(8'h4C, 32'd1);
      wr(8'h48, 32'd0);
      wr(8'h44, 32'h10);
      irq_src = 8'h08;
      tick();
      tick();
      tick();
      check("prio0_meip", {31'd0, meip}, 32'd0);
      rd("prio0_pending", 8'h40, 32'h10);
      rd("prio0_claim", 8'h4C, 32'd0);

      // ---- 5. bad completes, field masking, unmapped addresses ----
      wr(8'h4C, 32'd4);
      wr(8'h4C, 32'd9);
      rd("badcmpl_pending", 8'h40, 32'h10);
      wr(8'h08, 32'hFF);
      rd("prio_mask", 8'h08, 32'd7);
      wr(8'h44, 32'hFFFF_FFFF);
      rd("enable_mask", 8'h44, 32'h1FE);
      rd("rd_addr00", 8'h00, 32'd0);
      rd("rd_idx9", 8'h24, 32'd0);
      rd("rd_unmapped", 8'h80, 32'd0);
      check("badcmpl_meip", {31'd0, meip}, 32'd0);
      wr(8'h10, 32'd1);
      tick();
      check("src4_meip", {31'd0, meip}, 32'd1);

      // ---- 6. asynchronous reset in the middle of a claim ----
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h4C;
      #2 reset = 1'b1;
      #1;
      check("arst_meip", {31'd0, meip}, 32'd0);
      check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("arst_rsp_rdata", rsp_rdata, 32'd0);
      irq_src = '0;
      @(posedge clk);
      #1;
      check("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 1'b0; req_addr = '0;
      tick();
      check("arst_idle_rsp", {31'd0, rsp_valid}, 32'd0);
      rd("arst_prio4", 8'h10, 32'd0);
      rd("arst_prio1", 8'h04, 32'd0);
      rd("arst_enable", 8'h44, 32'd0);
      rd("arst_pending", 8'h40, 32'd0);
      rd("arst_thresh", 8'h48, 32'd0);
      check("arst_meip_after", {31'd0, meip}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
